// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller for the 5-stage core: per-stage stall/flush, PC redirect
// select, a RUN/DRAIN/WFI sequencer and saturating stall/redirect counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdu_load_stall,
    input  logic             ex_branch_take,
    input  logic             mem_busy,
    input  logic             mem_trap_req,
    input  logic             mem_mret_req,
    input  logic             mem_wfi_req,
    input  logic             irq_pending,
    input  logic             perf_cnt_clr,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             redirect_valid,
    output logic [1:0]       redirect_sel,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        WFI   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_BRANCH = 2'd0;
    localparam logic [1:0] SEL_TRAP   = 2'd1;
    localparam logic [1:0] SEL_MEPC   = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       pend_sel_q, pend_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       trap_or_mret;
    logic [1:0] trap_sel;

    assign trap_or_mret = mem_trap_req | mem_mret_req;
    assign trap_sel     = mem_trap_req ? SEL_TRAP : SEL_MEPC;

    // NOTE: every output and next-state value gets a default first so no path
    // through the priority chain can infer a latch.
    always_comb begin
        if_stall       = 1'b0;
        id_stall       = 1'b0;
        ex_stall       = 1'b0;
        if_flush       = 1'b0;
        id_flush       = 1'b0;
        ex_flush       = 1'b0;
        mem_flush      = 1'b0;
        redirect_valid = 1'b0;
        redirect_sel   = SEL_BRANCH;
        state_d        = state_q;
        pend_sel_d     = pend_sel_q;

        if (rst) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (trap_or_mret && !mem_busy) begin
                        redirect_valid = 1'b1;
                        redirect_sel   = trap_sel;
                        if_flush       = 1'b1;
                        id_flush       = 1'b1;
                        ex_flush       = 1'b1;
                        mem_flush      = 1'b1;
                    end else if (trap_or_mret) begin
                        if_stall   = 1'b1;
                        id_stall   = 1'b1;
                        ex_stall   = 1'b1;
                        mem_flush  = 1'b1;
                        pend_sel_d = trap_sel;
                        state_d    = DRAIN;
                    end else if (mem_busy) begin
                        // A taken branch in EX is frozen here and resolves again later.
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_stall  = 1'b1;
                        mem_flush = 1'b1;
                    end else if (mem_wfi_req) begin
                        if_stall = 1'b1;
                        id_stall = 1'b1;
                        ex_stall = 1'b1;
                        state_d  = WFI;
                    end else if (ex_branch_take) begin
                        redirect_valid = 1'b1;
                        redirect_sel   = SEL_BRANCH;
                        if_flush       = 1'b1;
                        id_flush       = 1'b1;
                    end else if (hdu_load_stall) begin
                        if_stall = 1'b1;
                        id_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_busy) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_stall  = 1'b1;
                        mem_flush = 1'b1;
                    end else begin
                        redirect_valid = 1'b1;
                        redirect_sel   = pend_sel_q;
                        if_flush       = 1'b1;
                        id_flush       = 1'b1;
                        ex_flush       = 1'b1;
                        mem_flush      = 1'b1;
                        state_d        = RUN;
                    end
                end
                WFI: begin
                    // Wake-up only leaves the state; the trap itself arrives via MEM.
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_stall  = 1'b1;
                    mem_flush = 1'b1;
                    if (irq_pending) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((if_stall || state_q != RUN) && !(&stall_cnt_q))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect_valid && !(&flush_cnt_q))
                flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_sel_q  <= SEL_BRANCH;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_sel_q  <= pend_sel_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard/redirect rules.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst, hdu_load_stall, ex_branch_take, mem_busy;
    logic mem_trap_req, mem_mret_req, mem_wfi_req, irq_pending, perf_cnt_clr;

    logic if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush, mem_flush;
    logic redirect_valid;
    logic [1:0] redirect_sel;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    logic s_if_stall, s_id_stall, s_ex_stall, s_if_flush, s_id_flush, s_ex_flush, s_mem_flush;
    logic s_redirect_valid;
    logic [1:0] s_redirect_sel;
    logic [3:0] s_perf_stall_cnt, s_perf_flush_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: sleeping in WFI, pending redirect select (-1 = none), counts since clear.
    bit          m_sleep;
    int          m_pend;
    int unsigned m_stall_cnt;
    int unsigned m_flush_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .hdu_load_stall(hdu_load_stall), .ex_branch_take(ex_branch_take),
        .mem_busy(mem_busy), .mem_trap_req(mem_trap_req), .mem_mret_req(mem_mret_req),
        .mem_wfi_req(mem_wfi_req), .irq_pending(irq_pending), .perf_cnt_clr(perf_cnt_clr),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .hdu_load_stall(hdu_load_stall), .ex_branch_take(ex_branch_take),
        .mem_busy(mem_busy), .mem_trap_req(mem_trap_req), .mem_mret_req(mem_mret_req),
        .mem_wfi_req(mem_wfi_req), .irq_pending(irq_pending), .perf_cnt_clr(perf_cnt_clr),
        .if_stall(s_if_stall), .id_stall(s_id_stall), .ex_stall(s_ex_stall),
        .if_flush(s_if_flush), .id_flush(s_id_flush), .ex_flush(s_ex_flush),
        .mem_flush(s_mem_flush), .redirect_valid(s_redirect_valid),
        .redirect_sel(s_redirect_sel),
        .perf_stall_cnt(s_perf_stall_cnt), .perf_flush_cnt(s_perf_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model mid-cycle,
    // advance the model, then cross the rising edge.
    task automatic step(input bit r, input bit load, input bit br, input bit busy,
                        input bit trap, input bit mret, input bit wfi, input bit irq,
                        input bit clr);
        bit stall3, flush4, memfl, ifst, idfl, ifl, rv;
        int sel;
        bit counted;
        logic [9:0] exp_ctrl, got_ctrl, got_ctrl_s;

        rst = r; hdu_load_stall = load; ex_branch_take = br; mem_busy = busy;
        mem_trap_req = trap; mem_mret_req = mret; mem_wfi_req = wfi;
        irq_pending = irq; perf_cnt_clr = clr;
        #4;

        stall3 = 0; flush4 = 0; memfl = 0; ifst = 0; idfl = 0; ifl = 0; rv = 0; sel = 0;
        if (r) begin
            flush4 = 1;
        end else if (m_sleep) begin
            stall3 = 1; memfl = 1;
        end else if (m_pend >= 0) begin
            if (busy) begin stall3 = 1; memfl = 1; end
            else begin rv = 1; sel = m_pend; flush4 = 1; end
        end else if (trap || mret) begin
            if (!busy) begin rv = 1; sel = trap ? 1 : 2; flush4 = 1; end
            else begin stall3 = 1; memfl = 1; end
        end else if (busy) begin
            stall3 = 1; memfl = 1;
        end else if (wfi) begin
            stall3 = 1;
        end else if (br) begin
            rv = 1; sel = 0; ifl = 1; idfl = 1;
        end else if (load) begin
            ifst = 1; idfl = 1;
        end

        exp_ctrl = {stall3 | ifst, stall3, stall3,
                    flush4 | ifl, flush4 | idfl, flush4, flush4 | memfl,
                    rv, 2'(sel)};
        got_ctrl = {if_stall, id_stall, ex_stall, if_flush, id_flush, ex_flush,
                    mem_flush, redirect_valid, redirect_sel};
        got_ctrl_s = {s_if_stall, s_id_stall, s_ex_stall, s_if_flush, s_id_flush,
                      s_ex_flush, s_mem_flush, s_redirect_valid, s_redirect_sel};
        check("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
        check("ctrl_cnt4", 32'(got_ctrl_s), 32'(exp_ctrl));
        check("stall_cnt", perf_stall_cnt, m_stall_cnt);
        check("flush_cnt", perf_flush_cnt, m_flush_cnt);
        check("stall_cnt_sat4", 32'(s_perf_stall_cnt), (m_stall_cnt > 15) ? 32'd15 : m_stall_cnt);
        check("flush_cnt_sat4", 32'(s_perf_flush_cnt), (m_flush_cnt > 15) ? 32'd15 : m_flush_cnt);

        if (r) begin
            m_sleep = 0; m_pend = -1; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            counted = stall3 || ifst || m_sleep || (m_pend >= 0);
            if (clr) begin
                m_stall_cnt = 0; m_flush_cnt = 0;
            end else begin
                if (counted) m_stall_cnt++;
                if (rv) m_flush_cnt++;
            end
            if (m_sleep) begin
                if (irq) m_sleep = 0;
            end else if (m_pend >= 0) begin
                if (!busy) m_pend = -1;
            end else if ((trap || mret) && busy) begin
                m_pend = trap ? 1 : 2;
            end else if (!(trap || mret) && !busy && wfi) begin
                m_sleep = 1;
            end
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; hdu_load_stall = 0; ex_branch_take = 0; mem_busy = 0;
        mem_trap_req = 0; mem_mret_req = 0; mem_wfi_req = 0; irq_pending = 0;
        perf_cnt_clr = 0;
        m_sleep = 0; m_pend = -1; m_stall_cnt = 0; m_flush_cnt = 0;
        @(posedge clk);
        #1;

        // Reset held, then idle.
        //      rst ld br bsy trp mrt wfi irq clr
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use bubble, then load stall masked by a taken branch.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Trap+mret behind a busy MEM access: drain, then trap vector.
        step(0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Immediate mret.
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // WFI sleep with branch requests ignored, then wake.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Saturation of the 4-bit instance, then clear alongside a stall.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset in the middle of a drain and of a sleep drops the pending work.
        step(0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
